alu_op_sequencer: RTL and testbench

//  Multi-cycle controller that runs one register-file/ALU operation per command.
//  Per command it reads two RF operands, drives the ALU, optionally writes the result back, and returns result + zero flag.

---
 rtl/alu_op_sequencer_pkg.sv | 27 ++
 rtl/alu_op_sequencer_if.sv | 63 ++++++
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Purpose : shared types and constants for the ALU operation sequencer.
// Contents: FSM state encoding, ALU opcode constants, default widths.
// Ports   : none (package).
package alu_seq_pkg;

  // Default widths. The top module exposes these as overridable parameters.
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned OP_W_DEF   = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  // One command in flight: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Opcodes understood by the external ALU instance.
  localparam logic [4:0] ALUOP_ADD = 5'd0;
  localparam logic [4:0] ALUOP_SUB = 5'd1;
  localparam logic [4:0] ALUOP_AND = 5'd2;
  localparam logic [4:0] ALUOP_OR  = 5'd3;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Purpose : bundles the command, register-file, ALU and response signals of the sequencer.
// Modports: master = the sequencer (accepts commands, drives RF/ALU, returns responses);
//           slave  = its environment (command source, RF, ALU and response consumer).
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5
) ();

  // command channel (valid/ready)
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;
  logic [OP_W-1:0]   cmd_op;
  logic              cmd_wb;

  // register file: two combinational reads, one write port
  logic [ADDR_W-1:0] rf_a1;
  logic [ADDR_W-1:0] rf_a2;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  // ALU: combinational result and zero flag
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_c;
  logic              alu_zero;

  // response channel (valid/ready)
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;

  modport master (
    input  cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_wb,
    output cmd_ready,
    output rf_a1, rf_a2, rf_a3, rf_wd, rf_we,
    input  rf_rd1, rf_rd2,
    output alu_a, alu_b, alu_op,
    input  alu_c, alu_zero,
    output rsp_valid, rsp_data, rsp_zero,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_wb,
    input  cmd_ready,
    input  rf_a1, rf_a2, rf_a3, rf_wd, rf_we,
    output rf_rd1, rf_rd2,
    input  alu_a, alu_b, alu_op,
    output alu_c, alu_zero,
    input  rsp_valid, rsp_data, rsp_zero,
    output rsp_ready
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose : sequences one RF-read / ALU / optional write-back operation per command.
// Latency : accept at cycle N, rf_we pulse at N+3, rsp_valid from N+4; at least 5 cycles per command.
// Backpr. : cmd_ready only in IDLE; RESP holds rsp_valid/data/zero until rsp_ready.
// Ports   : clk, rstn (synchronous, active-high: 1 = reset), bus (alu_op_sequencer_if.master:
//           cmd_*, rf_*, alu_*, rsp_*), busy (not IDLE), op_count (completed responses, wraps).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  alu_op_sequencer_if.master  bus,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [ADDR_W-1:0] r_rd;
  logic [OP_W-1:0]   r_op;
  logic              r_wb;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_rf_we;
  logic              w_rsp_valid;
  logic              w_rsp_done;
  logic              w_busy;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and qualified outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_rf_we     = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_busy      = 1'b0;
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WB;
      end
      S_WB: begin
        // x0 is hard-wired zero in the RF, so a write to it is suppressed here.
        w_rf_we = r_wb && (r_rd != '0);
        w_next  = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Reset aborts in the same cycle: no write pulse, no response, no new accept.
    if (rstn) begin
      w_cmd_ready = 1'b0;
      w_rf_we     = 1'b0;
      w_rsp_valid = 1'b0;
    end
  end

  assign w_accept   = w_cmd_ready & bus.cmd_valid;
  assign w_rsp_done = w_rsp_valid & bus.rsp_ready;

  // ---------------------------------------------------------------------------
  // Command, operand, result registers and completion counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_op       <= '0;
      r_wb       <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_rs1 <= bus.cmd_rs1;
        r_rs2 <= bus.cmd_rs2;
        r_rd  <= bus.cmd_rd;
        r_op  <= bus.cmd_op;
        r_wb  <= bus.cmd_wb;
      end
      // RF read data is combinational from rf_a1/rf_a2, which already carry rs1/rs2 here.
      if (r_state == S_READ) begin
        r_opa <= bus.rf_rd1;
        r_opb <= bus.rf_rd2;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= bus.alu_c;
        r_rsp_zero <= bus.alu_zero;
      end
      if (w_rsp_done) begin
        r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: addresses/data/opcodes are plain register views and keep their last
  // value outside the state that uses them; only rf_we and rsp_valid are qualified.
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready = w_cmd_ready;

  assign bus.rf_a1     = r_rs1;
  assign bus.rf_a2     = r_rs2;
  assign bus.rf_a3     = r_rd;
  assign bus.rf_wd     = r_rsp_data;
  assign bus.rf_we     = w_rf_we;

  assign bus.alu_a     = r_opa;
  assign bus.alu_b     = r_opb;
  assign bus.alu_op    = r_op;

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;

  assign busy          = w_busy;
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: register-file and ALU environment, directed scenarios followed by
// randomized commands, a reference model that predicts responses and write-backs per command,
// and a negedge monitor that pops the expectations whenever the DUT presents rf_we or rsp_valid.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          busy;
  logic [CW-1:0] op_count;

  alu_op_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) bus ();

  alu_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus.master),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: RF (x0 = 0) and ALU ----------------
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_AND: return a & b;
      ALUOP_OR:  return a | b;
      default:   return 32'h0;
    endcase
  endfunction

  logic [31:0] rf_mem [32] = '{default: '0};
  logic        poke_en = 1'b0;
  logic [4:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  always @(posedge clk) begin
    if (poke_en) rf_mem[poke_idx] <= poke_val;
    else if (bus.rf_we && bus.rf_a3 != 5'd0) rf_mem[bus.rf_a3] <= bus.rf_wd;
  end

  assign bus.rf_rd1   = rf_mem[bus.rf_a1];
  assign bus.rf_rd2   = rf_mem[bus.rf_a2];
  assign bus.alu_c    = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_c == 32'h0);

  // ---------------- checking bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    int          cyc;
  } wr_exp_t;

  rsp_exp_t    rq[$];
  wr_exp_t     wq[$];
  logic [31:0] ref_rf [32];
  int          done_cnt    = 0;
  int          last_hs_cyc = -1;
  int          hold        = 0;
  int          hold_max    = 0;
  int          stall_cnt   = 0;

  // ---------------- monitor ----------------
  logic     prev_valid = 1'b0;
  rsp_exp_t cur;
  wr_exp_t  w;

  always @(negedge clk) begin
    if (rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.rf_we) begin
        if (wq.size() == 0) check("rf_we_expected", 32'(wq.size()), 32'd1);
        else begin
          w = wq.pop_front();
          check("wb_addr", 32'(bus.rf_a3), 32'(w.rd));
          check("wb_data", bus.rf_wd, w.wd);
          check("wb_cycle", cyc, w.cyc);
        end
      end
      if (bus.rsp_valid) begin
        check("cmd_ready_low_in_resp", 32'(bus.cmd_ready), 32'd0);
        if (!prev_valid) begin
          if (rq.size() == 0) check("rsp_expected", 32'(rq.size()), 32'd1);
          else begin
            cur = rq.pop_front();
            check("rsp_data", bus.rsp_data, cur.data);
            check("rsp_zero", 32'(bus.rsp_zero), 32'(cur.zero));
            check("rsp_cycle", cyc, cur.cyc);
            check("alu_a", bus.alu_a, cur.a);
            check("alu_b", bus.alu_b, cur.b);
            check("alu_op", 32'(bus.alu_op), 32'(cur.op));
            check("op_count_before", 32'(op_count), done_cnt);
            hold = 0;
          end
        end else begin
          check("rsp_data_stable", bus.rsp_data, cur.data);
          check("rsp_zero_stable", 32'(bus.rsp_zero), 32'(cur.zero));
        end
        if (bus.rsp_ready) begin
          done_cnt++;
          last_hs_cyc = cyc;
          if (hold > hold_max) hold_max = hold;
        end else begin
          hold++;
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // ---------------- response consumer ----------------
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) stall_cnt--;
      end else begin
        bus.rsp_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic poke(input logic [4:0] idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = (idx == 5'd0) ? 32'h0 : val;
    ref_rf[idx] = (idx == 5'd0) ? 32'h0 : val;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [4:0] op, input logic wb);
    int       n;
    logic     accepted;
    rsp_exp_t e;
    wr_exp_t  x;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_rd    = rd;
    bus.cmd_op    = op;
    bus.cmd_wb    = wb;
    bus.cmd_valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (bus.cmd_ready) accepted = 1'b1;
      else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (!accepted) begin
      check("accept_within_budget", 32'(accepted), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    check("busy_low_at_accept", 32'(busy), 32'd0);
    check("prev_rsp_consumed", 32'(rq.size()), 32'd0);
    check("accept_after_handshake", 32'(cyc > last_hs_cyc), 32'd1);
    e.a    = ref_rf[rs1];
    e.b    = ref_rf[rs2];
    e.op   = op;
    e.data = alu_ref(op, e.a, e.b);
    e.zero = (e.data == 32'h0);
    e.cyc  = cyc + 4;
    rq.push_back(e);
    if (wb && rd != 5'd0) begin
      x.rd  = rd;
      x.wd  = e.data;
      x.cyc = cyc + 3;
      wq.push_back(x);
      ref_rf[rd] = e.data;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs1   = 5'($urandom);
    bus.cmd_rs2   = 5'($urandom);
    bus.cmd_op    = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_rsp_queue_empty", 32'(rq.size()), 32'd0);
    check("drain_wb_queue_empty", 32'(wq.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] saved [32];

  initial begin
    rstn          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_rd    = '0;
    bus.cmd_op    = '0;
    bus.cmd_wb    = 1'b0;
    ref_rf[0]     = 32'h0;
    @(posedge clk);
    #1;
    for (int i = 1; i < 32; i++) poke(5'(i), $urandom);

    // reset state
    @(negedge clk);
    check("reset_rf_we", 32'(bus.rf_we), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    check("reset_rf_a1", 32'(bus.rf_a1), 32'd0);
    check("reset_alu_a", bus.alu_a, 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: ADD 5+3 -> R4
    poke(5'd1, 32'd5);
    poke(5'd2, 32'd3);
    send(5'd1, 5'd2, 5'd4, ALUOP_ADD, 1'b1);
    drain();
    check("t1_r4", rf_mem[4], 32'd8);
    check("t1_op_count", 32'(op_count), 32'd1);

    // 2: SUB 7-7, no write-back
    poke(5'd1, 32'd7);
    poke(5'd2, 32'd7);
    send(5'd1, 5'd2, 5'd5, ALUOP_SUB, 1'b0);
    drain();
    check("t2_r5_unchanged", rf_mem[5], ref_rf[5]);

    // 3: write-back to x0 is suppressed
    poke(5'd1, 32'd1);
    poke(5'd2, 32'd1);
    send(5'd1, 5'd2, 5'd0, ALUOP_ADD, 1'b1);
    drain();
    check("t3_r0_zero", rf_mem[0], 32'd0);

    // 4: response held 10 cycles while a second command waits
    hold_max  = 0;
    stall_cnt = 10;
    send(5'd3, 5'd4, 5'd6, ALUOP_OR, 1'b1);
    send(5'd6, 5'd6, 5'd7, ALUOP_AND, 1'b1);
    drain();
    check("t4_stall_held_10", 32'(hold_max >= 10), 32'd1);

    // 5: back-to-back, second reads the first's write-back
    poke(5'd1, 32'd4);
    poke(5'd2, 32'd5);
    send(5'd1, 5'd2, 5'd3, ALUOP_ADD, 1'b1);
    send(5'd3, 5'd0, 5'd8, ALUOP_ADD, 1'b1);
    drain();
    check("t5_r8", rf_mem[8], 32'd9);

    // 6: reset during EXEC
    poke(5'd1, 32'd11);
    poke(5'd2, 32'd22);
    for (int i = 0; i < 32; i++) saved[i] = ref_rf[i];
    send(5'd1, 5'd2, 5'd9, ALUOP_ADD, 1'b1);
    @(posedge clk);
    #1;
    check("t6_busy_in_exec", 32'(busy), 32'd1);
    rstn = 1'b1;
    rq.delete();
    wq.delete();
    for (int i = 0; i < 32; i++) ref_rf[i] = saved[i];
    @(posedge clk);
    #1;
    done_cnt = 0;
    @(negedge clk);
    check("t6_rf_we", 32'(bus.rf_we), 32'd0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_op_count", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) check("t6_rf_unchanged", rf_mem[i], ref_rf[i]);

    // randomized commands with random gaps and random response backpressure
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain();
    check("final_op_count", 32'(op_count), done_cnt);
    for (int i = 0; i < 8; i++) check("final_rf", rf_mem[i], ref_rf[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
